// File: rtl/mult_pipe.sv
// mult_pipe: fully pipelined RV M-extension multiplier (MUL/MULH/MULHSU/MULHU) with tag,
// back-pressure and flush. Optional last-result reuse cache: define MULT_RESULT_REUSE_EN.
module mult_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3,
    parameter int TAG_W  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         mult_op,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [TAG_W-1:0]   in_tag,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] C,
    output logic [WIDTH-1:0]   rd_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               mult_stall
);
    localparam int PW   = 2 * WIDTH;
    localparam int LAST = STAGES - 1;

    // Signedness class of a product; MUL shares the unsigned class (low half is class-independent).
    typedef enum logic [1:0] {CLS_UU = 2'd0, CLS_SS = 2'd1, CLS_SU = 2'd2} cls_t;

    cls_t            cls_d;
    logic            hi_d, a_sgn, b_sgn;
    logic [PW-1:0]   a_wide, b_wide, prod_d;
    logic            adv, fire, hit, rdy_en_q;
    logic [PW-1:0]   hit_prod;
    cls_t            hit_cls;

    logic            valid_q [STAGES];
    logic            hi_q    [STAGES];
    cls_t            cls_q   [STAGES];
    logic [TAG_W-1:0] tag_q  [STAGES];
    logic [PW-1:0]   prod_q  [STAGES];

    always_comb begin
        cls_d = CLS_UU;
        hi_d  = 1'b0;
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (mult_op)
            3'b001:  begin cls_d = CLS_SS; hi_d = 1'b1; a_sgn = 1'b1; b_sgn = 1'b1; end
            3'b010:  begin cls_d = CLS_SU; hi_d = 1'b1; a_sgn = 1'b1; end
            3'b011:  begin cls_d = CLS_UU; hi_d = 1'b1; end
            default: begin cls_d = CLS_UU; hi_d = 1'b0; end
        endcase
    end

    // Extending to PW bits and keeping the low PW bits of the product equals the
    // WIDTH+1-bit signed product truncated to 2*WIDTH bits.
    assign a_wide = {{WIDTH{a_sgn & A[WIDTH-1]}}, A};
    assign b_wide = {{WIDTH{b_sgn & B[WIDTH-1]}}, B};
    assign prod_d = a_wide * b_wide;

    // Handshake: an input is taken on a rising edge where in_valid && in_ready; a result
    // leaves on a rising edge where out_valid && out_ready. While out_valid && !out_ready
    // the whole pipe, bubbles included, holds and the outputs stay stable.
    assign adv        = !out_valid || out_ready;
    assign in_ready   = rdy_en_q && adv && !flush;
    assign fire       = in_valid && in_ready;
    assign mult_stall = in_valid && !in_ready;

    assign out_valid = valid_q[LAST];
    assign C         = prod_q[LAST];
    assign out_tag   = tag_q[LAST];
    assign rd_data   = hi_q[LAST] ? prod_q[LAST][PW-1:WIDTH] : prod_q[LAST][WIDTH-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_en_q <= 1'b0;
            for (int i = 0; i < STAGES; i++) begin
                valid_q[i] <= 1'b0;
                hi_q[i]    <= 1'b0;
                cls_q[i]   <= CLS_UU;
                tag_q[i]   <= '0;
                prod_q[i]  <= '0;
            end
        end else begin
            rdy_en_q <= 1'b1;
            if (adv) begin
                valid_q[0] <= fire && !hit;
                hi_q[0]    <= hi_d;
                cls_q[0]   <= cls_d;
                tag_q[0]   <= in_tag;
                prod_q[0]  <= prod_d;
                for (int i = 1; i < STAGES; i++) begin
                    valid_q[i] <= valid_q[i-1];
                    hi_q[i]    <= hi_q[i-1];
                    cls_q[i]   <= cls_q[i-1];
                    tag_q[i]   <= tag_q[i-1];
                    prod_q[i]  <= prod_q[i-1];
                end
                if (hit) begin
                    valid_q[LAST] <= 1'b1;
                    hi_q[LAST]    <= hi_d;
                    cls_q[LAST]   <= hit_cls;
                    tag_q[LAST]   <= in_tag;
                    prod_q[LAST]  <= hit_prod;
                end
            end
            if (flush) begin
                for (int i = 0; i < STAGES; i++) valid_q[i] <= 1'b0;
            end
        end
    end

`ifdef MULT_RESULT_REUSE_EN
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic             cache_vld_q, pipe_empty;
    logic [WIDTH-1:0] cache_a_q, cache_b_q;
    cls_t             cache_cls_q;
    logic [PW-1:0]    cache_c_q;

    always_comb begin
        pipe_empty = 1'b1;
        for (int i = 0; i < STAGES; i++) if (valid_q[i]) pipe_empty = 1'b0;
    end

    // The cached class records how the stored C was computed, so a MUL hit that reuses a
    // MULH product keeps the MULH class for later lookups.
    assign hit = fire && cache_vld_q && pipe_empty && (A == cache_a_q) && (B == cache_b_q)
                 && (!hi_d || (cls_d == cache_cls_q));
    assign hit_prod = cache_c_q;
    assign hit_cls  = cache_cls_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cache_vld_q <= 1'b0;
            cache_a_q   <= '0;
            cache_b_q   <= '0;
            cache_cls_q <= CLS_UU;
            cache_c_q   <= '0;
            for (int i = 0; i < STAGES; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            if (adv) begin
                a_q[0] <= A;
                b_q[0] <= B;
                for (int i = 1; i < STAGES; i++) begin
                    a_q[i] <= a_q[i-1];
                    b_q[i] <= b_q[i-1];
                end
                if (hit) begin
                    a_q[LAST] <= A;
                    b_q[LAST] <= B;
                end
            end
            if (out_valid && out_ready) begin
                cache_vld_q <= 1'b1;
                cache_a_q   <= a_q[LAST];
                cache_b_q   <= b_q[LAST];
                cache_cls_q <= cls_q[LAST];
                cache_c_q   <= prod_q[LAST];
            end
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_prod = '0;
    assign hit_cls  = CLS_UU;
`endif

endmodule

// File: tb/tb_mult_pipe.sv
// Directed + random bench for mult_pipe (default parameters) with a tag/result scoreboard.
module tb_mult_pipe;
  localparam int W      = 32;
  localparam int STAGES = 3;
  localparam int TAG_W  = 5;
  localparam int EW     = TAG_W + W + 2*W;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       mult_op;
  logic [W-1:0]     A;
  logic [W-1:0]     B;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   C;
  logic [W-1:0]     rd_data;
  logic [TAG_W-1:0] out_tag;
  logic             mult_stall;

  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];

  mult_pipe #(.WIDTH(W), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mult_op    (mult_op),
    .A          (A),
    .B          (B),
    .in_tag     (in_tag),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .C          (C),
    .rd_data    (rd_data),
    .out_tag    (out_tag),
    .mult_stall (mult_stall)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [2*W-1:0] sa, za, sb, zb;
    sa = {{W{a[W-1]}}, a};
    za = {{W{1'b0}}, a};
    sb = {{W{b[W-1]}}, b};
    zb = {{W{1'b0}}, b};
    case (op)
      OP_MULH:   return sa * sb;
      OP_MULHSU: return sa * zb;
      default:   return za * zb;
    endcase
  endfunction

  function automatic logic [EW-1:0] mk_exp(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [TAG_W-1:0] t);
    logic [2*W-1:0] c;
    logic [W-1:0]   rd;
    c  = model(op, a, b);
    rd = (op == OP_MULH || op == OP_MULHSU || op == OP_MULHU) ? c[2*W-1:W] : c[W-1:0];
    return {t, rd, c};
  endfunction

  // driver tasks
  task automatic accept(input bit en, input logic [EW-1:0] e);
    bit ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept_timeout", ok, 1);
    if (ok && en) exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [TAG_W-1:0] t, input bit en, input logic [EW-1:0] e);
    in_valid = 1'b1;
    mult_op  = op;
    A        = a;
    B        = b;
    in_tag   = t;
    accept(en, e);
  endtask

  task automatic check_latency(input string tag);
    for (int e = 1; e < STAGES; e++) begin
      check({tag, "_early"}, out_valid, 0);
      @(posedge clk);
      #1;
    end
    check({tag, "_due"}, out_valid, 1);
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(posedge clk);
    check("drain", exp_q.size(), 0);
    #1;
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", out_valid, 0);
      end else begin
        check("result", {out_tag, rd_data, C}, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [2*W-1:0] pexp;
    rst = 1'b0; in_valid = 1'b0; mult_op = '0; A = '0; B = '0; in_tag = '0;
    flush = 1'b0; out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_c", C, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_out_tag", out_tag, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", in_ready, 1);

    send(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 1'b1,
         {5'd3, 32'hFFFFFFFE, 64'hFFFFFFFE00000001});
    check_latency("mulhu_lat");
    drain();

    send(OP_MULH, 32'h80000000, 32'h80000000, 5'd4, 1'b1,
         {5'd4, 32'h40000000, 64'h4000000000000000});
    send(OP_MULHSU, 32'hFFFFFFFF, 32'h00000002, 5'd5, 1'b1,
         {5'd5, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFE});
    send(OP_MUL, 32'h0, 32'h12345, 5'd6, 1'b1, {5'd6, 32'h0, 64'h0});
    send(OP_MULH, 32'h0, 32'hFFFFFFFF, 5'd7, 1'b1, {5'd7, 32'h0, 64'h0});
    send(3'b110, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 1'b1,
         {5'd8, 32'h00000001, 64'hFFFFFFFE00000001});
    drain();

    for (int i = 0; i < 16; i++) begin
      logic [2:0] op;
      logic [W-1:0] a, b;
      logic [TAG_W-1:0] t;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      t  = TAG_W'($urandom_range(0, 31));
      send(op, a, b, t, 1'b1, mk_exp(op, a, b, t));
    end
    drain();

    // back-pressure: three ops fill the pipe, a fourth stalls
    out_ready = 1'b0;
    send(OP_MUL, 32'd3, 32'd5, 5'd1, 1'b1, mk_exp(OP_MUL, 32'd3, 32'd5, 5'd1));
    send(OP_MUL, 32'd7, 32'd9, 5'd2, 1'b1, mk_exp(OP_MUL, 32'd7, 32'd9, 5'd2));
    send(OP_MUL, 32'd11, 32'd13, 5'd3, 1'b1, mk_exp(OP_MUL, 32'd11, 32'd13, 5'd3));
    in_valid = 1'b1; mult_op = OP_MUL; A = 32'd17; B = 32'd19; in_tag = 5'd4;
    @(negedge clk);
    check("bp_stall", mult_stall, 1);
    check("bp_head", {out_valid, out_tag, C}, {1'b1, 5'd1, 64'd15});
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_stall_hold", mult_stall, 1);
    check("bp_hold", {out_valid, out_tag, rd_data}, {1'b1, 5'd1, 32'd15});
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    accept(1'b1, mk_exp(OP_MUL, 32'd17, 32'd19, 5'd4));
    drain();

    // flush with two ops in flight and a new request presented
    send(OP_MUL, 32'd5, 32'd5, 5'd6, 1'b0, '0);
    send(OP_MUL, 32'd6, 32'd6, 5'd7, 1'b0, '0);
    in_valid = 1'b1; mult_op = OP_MUL; A = 32'd7; B = 32'd7; in_tag = 5'd8; flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < STAGES + 2; i++) begin
      check("flush_no_out", out_valid, 0);
      @(posedge clk);
      #1;
    end

    // asynchronous reset while a result is being presented
    out_ready = 1'b0;
    send(OP_MUL, 32'd9, 32'd9, 5'd9, 1'b0, '0);
    repeat (STAGES - 1) @(posedge clk);
    @(negedge clk);
    check("pre_rst_valid", {out_valid, C}, {1'b1, 64'd81});
    #2;
    rst = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_c", C, 0);
    check("midrst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    send(OP_MUL, 32'd2, 32'd2, 5'd10, 1'b1, {5'd10, 32'd4, 64'd4});
    check_latency("post_rst_lat");
    drain();

`ifdef MULT_RESULT_REUSE_EN
    send(OP_MULH, 32'h12345678, 32'h9ABCDEF0, 5'd11, 1'b1,
         mk_exp(OP_MULH, 32'h12345678, 32'h9ABCDEF0, 5'd11));
    drain();
    @(posedge clk);
    #1;
    pexp = model(OP_MULH, 32'h12345678, 32'h9ABCDEF0);
    send(OP_MUL, 32'h12345678, 32'h9ABCDEF0, 5'd12, 1'b1, {5'd12, pexp[W-1:0], pexp});
    check("reuse_lat", out_valid, 1);
    drain();
`else
    pexp = '0;
`endif

    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
